// File: rtl/cpu_cpu_cpu_mul_combine.sv
// Combines the multiply cell's three 16x16 partial products into the low 32 bits
// of a 32x32 product, tracking the destination tag through M -> A -> W slots.
module cpu_cpu_cpu_mul_combine #(
    parameter int DST_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             M_en,
    input  logic             E_valid,
    input  logic [DST_W-1:0] E_dst,
    input  logic [31:0]      M_mul_cell_p1,
    input  logic [31:0]      M_mul_cell_p2,
    input  logic [31:0]      M_mul_cell_p3,
    input  logic             M_flush,
    input  logic             W_ready,
    output logic             W_mul_valid,
    output logic [31:0]      W_mul_result,
    output logic [DST_W-1:0] W_mul_dst,
    output logic             mul_stall,
    output logic             mul_busy
);

    logic             m_valid_q, m_valid_d;
    logic [DST_W-1:0] m_dst_q, m_dst_d;
    logic             a_valid_q, a_valid_d;
    logic [31:0]      a_lo_q, a_lo_d;
    logic [15:0]      a_mid_q, a_mid_d;
    logic [DST_W-1:0] a_dst_q, a_dst_d;
    logic             w_valid_q, w_valid_d;
    logic [31:0]      w_result_q, w_result_d;
    logic [DST_W-1:0] w_dst_q, w_dst_d;

    logic a_can_accept;
    logic a_to_w;
    logic m_to_a;

    // Upper product halves only contribute to bits 63:32 of the full product.
    logic unused_hi;
    assign unused_hi = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

    always_comb begin
        a_can_accept = ~a_valid_q | ~w_valid_q | W_ready;
        // A flushed A slot must not leak into W, so the move is gated by flush too.
        a_to_w       = a_valid_q & (~w_valid_q | W_ready) & ~M_flush;
        m_to_a       = m_valid_q & a_can_accept & ~M_flush;
    end

    always_comb begin
        m_valid_d  = m_valid_q;
        m_dst_d    = m_dst_q;
        a_valid_d  = a_valid_q;
        a_lo_d     = a_lo_q;
        a_mid_d    = a_mid_q;
        a_dst_d    = a_dst_q;
        w_valid_d  = w_valid_q;
        w_result_d = w_result_q;
        w_dst_d    = w_dst_q;

        if (M_flush) begin
            m_valid_d = 1'b0;
        end else if (M_en) begin
            m_valid_d = E_valid;
            m_dst_d   = E_dst;
        end else if (m_to_a) begin
            m_valid_d = 1'b0;
        end

        if (M_flush) begin
            a_valid_d = 1'b0;
        end else if (m_to_a) begin
            a_valid_d = 1'b1;
            a_lo_d    = M_mul_cell_p1;
            a_mid_d   = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
            a_dst_d   = m_dst_q;
        end else if (a_to_w) begin
            a_valid_d = 1'b0;
        end

        if (a_to_w) begin
            w_valid_d  = 1'b1;
            w_result_d = a_lo_q + {a_mid_q, 16'h0000};
            w_dst_d    = a_dst_q;
        end else if (W_ready) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q  <= 1'b0;
            m_dst_q    <= '0;
            a_valid_q  <= 1'b0;
            a_lo_q     <= '0;
            a_mid_q    <= '0;
            a_dst_q    <= '0;
            w_valid_q  <= 1'b0;
            w_result_q <= '0;
            w_dst_q    <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_dst_q    <= m_dst_d;
            a_valid_q  <= a_valid_d;
            a_lo_q     <= a_lo_d;
            a_mid_q    <= a_mid_d;
            a_dst_q    <= a_dst_d;
            w_valid_q  <= w_valid_d;
            w_result_q <= w_result_d;
            w_dst_q    <= w_dst_d;
        end
    end

    assign W_mul_valid  = w_valid_q;
    assign W_mul_result = w_result_q;
    assign W_mul_dst    = w_dst_q;
    assign mul_stall    = m_valid_q & ~a_can_accept;
    assign mul_busy     = m_valid_q | a_valid_q | w_valid_q;

endmodule

// File: doc/cpu_cpu_cpu_mul_combine.md
# cpu_cpu_cpu_mul_combine

Downstream companion to the CPU multiply cell. It consumes the three registered 16x16 partial products the cell presents in M stage and forms the low 32 bits of the 32x32 product. It also carries the destination-register tag through a two-stage pipeline and hands the result to writeback with a valid/ready handshake. It exerts backpressure on M stage through `mul_stall` so the cell never overwrites unconsumed products.

## Interface
- `DST_W`, default 5: destination tag width.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `M_en`  in  1  M-stage advance; same signal that enables the multiply cell registers.
- `E_valid`  in  1  MUL instruction in E stage this cycle; sampled only when `M_en`=1.
- `E_dst`  in  DST_W  destination tag of the E-stage MUL.
- `M_mul_cell_p1`  in  32  src1[15:0]*src2[15:0], registered by the cell.
- `M_mul_cell_p2`  in  32  src1[15:0]*src2[31:16].
- `M_mul_cell_p3`  in  32  src1[31:16]*src2[15:0].
- `M_flush`  in  1  kill M and A slots; synchronous.
- `W_ready`  in  1  writeback accepts the result this cycle.
- `W_mul_valid`  out  1  result slot occupied.
- `W_mul_result`  out  32  low 32 bits of src1*src2.
- `W_mul_dst`  out  DST_W  destination tag of the result.
- `mul_stall`  out  1  M stage must hold (`M_en` low) next cycle.
- `mul_busy`  out  1  any slot occupied.

## Operation
- Three slots: M (tag only, products held by the cell), A (partial sums), W (output register).
- M slot loads:
  - On `M_en`=1: `m_valid`<=`E_valid`, `m_dst`<=`E_dst`.
  - On `M_en`=0: `m_valid` clears if its contents moved to A this cycle; otherwise it holds.
- A slot:
  - Accepts when `m_valid` and (A empty, or A moves to W this cycle).
  - On load: `a_lo`<=p1; `a_mid`<=(p2[15:0]+p3[15:0]) mod 2^16; `a_dst`<=`m_dst`.
  - p2[31:16] and p3[31:16] are ignored; they only affect bits 63:32.
- W slot:
  - Accepts from A when A valid and (W empty or `W_ready`).
  - `W_mul_result`<=(`a_lo` + {`a_mid`,16'h0}) mod 2^32.
  - `W_mul_valid` clears on `W_ready` when nothing loads.
- `mul_stall` = `m_valid` & ~(A can accept). This is combinational from slot state and `W_ready`.
- Driving `M_en`=1 while `mul_stall`=1 is a protocol violation. The bench flags it with an assertion; the RTL behaviour is undefined.
- `M_flush`:
  - Clears `m_valid` and `a_valid`.
  - An E-stage MUL presented in the same cycle is not captured.
  - W slot is committed and unaffected.
  - Flush takes precedence over any load into M or A.
- `mul_busy` = `m_valid` | `a_valid` | `W_mul_valid`.
- Reset: all valid bits 0; `W_mul_result` 0, `W_mul_dst` 0, `mul_stall` 0, `mul_busy` 0; data registers 0.

## Timing
- Issue is `E_valid`&`M_en` sampled at edge N. The cell registers products at N, A loads at N+1, W loads at N+2.
- `W_mul_valid` is high from edge N+2, so latency is 2 cycles after issue.
- Throughput is one MUL per cycle while `W_ready`=1 and `M_en`=1.
- With `W_ready` held low: W fills, then A, then `mul_stall` rises in the same cycle M holds a valid op that cannot move. At most 3 ops are in flight (M, A, W).
- When `W_ready` rises: W drains that edge, A moves to W and M moves to A on the same edge, and `mul_stall` drops combinationally in that cycle.
- Reset is asynchronous assert. Deassertion is synchronised externally; the first edge after deassert can issue.

## Test plan
- Basic: src1=0x00030002, src2=0x00050004, `E_dst`=7, `W_ready`=1 -> two cycles later `W_mul_valid`=1, result 0x00160008, dst 7.
- Wrap: src1=src2=0xFFFFFFFF (p1=p2=p3=0xFFFE0001) -> result 0x00000001. A second case with p2[15:0]+p3[15:0] overflowing 16 bits must show the carry discarded.
- Back-to-back: 4 MULs on consecutive cycles with `W_ready`=1 -> 4 results on consecutive cycles, in order, tags intact; `mul_stall` never asserts.
- Backpressure: `W_ready`=0, issue 3 MULs -> W, A, M full and `mul_stall`=1. Raise `W_ready` -> results drain one per cycle, in order, with no loss or duplication.
- Flush: issue MUL A then B; assert `M_flush` while A is in the A slot and B in M -> neither appears at W. A MUL already in W still completes. A MUL presented with the flush is dropped.
- Reset mid-operation: assert `reset` with all slots full -> all outputs 0 immediately (asynchronous). Post-reset issue of 0x00000002*0x00000003 -> result 0x00000006.
